qed_dup_scheduler: RTL and testbench

- Sequences original and duplicate instruction issue for SQED checking on the steelcore fetch path.
- Sits between the symbolic instruction source (already constrained to ADDI/ANDI/.../R-type/LW/SW/NOP over x0-x15) and the core fetch port.
- In ORIG mode, passes original instructions through and records them in a FIFO. In DUP mode, replays them remapped to the duplicate register and memory half.
- After the pipeline drains, raises qed_check_valid so the consistency checker compares the x0-x15 state against the x16-x31 state.

---
 rtl/qed_dup_scheduler.sv | 155 +++++++++++++++
 tb/tb_qed_dup_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_scheduler.sv
// SQED issue sequencer: ORIG pass-through and record, DUP replay remapped to x16-x31 and the upper memory half, drain, then check.
// Optional: define QED_NOP_FILTER_EN to keep NOPs out of the original stream (not issued as valid, pushed or counted).
module qed_dup_scheduler #(
   parameter int DEPTH        = 8,
   parameter int DRAIN_CYCLES = 5,
   parameter int CNT_W        = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             exec_dup,
   input  logic [31:0]      ifu_qed_instruction,
   input  logic             stall_IF,
   output logic [31:0]      qed_ifu_instruction,
   output logic             vld_out,
   output logic             qed_check_valid,
   output logic [CNT_W-1:0] num_orig,
   output logic [CNT_W-1:0] num_dup,
   output logic             buf_full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = $clog2(DRAIN_CYCLES + 2);
   localparam logic [AW:0]       L_DEPTH = (AW + 1)'(DEPTH);
   localparam logic [AW:0]       L_ONE   = (AW + 1)'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [31:0]       NOP     = 32'h0000007F;
   localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;

   typedef enum logic [1:0] {S_ORIG, S_DUP, S_DRAIN, S_CHECK} state_t;

   state_t            r_state;
   logic [31:0]       r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr, r_rd_ptr;
   logic [31:0]       r_out;
   logic              r_vld, r_check;
   logic [CNT_W-1:0]  r_num_orig, r_num_dup;
   logic [DW-1:0]     r_drain;

   logic              w_adv, w_empty, w_full, w_filtered, w_push, w_fill;
   logic [AW:0]       w_level;
   logic [31:0]       w_head, w_dup;

   function automatic logic [4:0] remap(input logic [4:0] f);
      return (f == 5'd0) ? f : (f | 5'h10);
   endfunction

   assign w_adv   = ena & ~stall_IF;
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == L_DEPTH);
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

`ifdef QED_NOP_FILTER_EN
   assign w_filtered = (ifu_qed_instruction[6:0] == 7'h7F);
`else
   assign w_filtered = 1'b0;
`endif

   assign w_push = w_adv && (r_state == S_ORIG) && !w_filtered;
   // The push that brings the FIFO to DEPTH entries forces the switch to replay.
   assign w_fill = w_push && (w_level == L_DEPTH - L_ONE);

   always_comb begin
      w_dup = w_head;
      case (w_head[6:0])
         OP_R: begin
            w_dup[11:7]  = remap(w_head[11:7]);
            w_dup[19:15] = remap(w_head[19:15]);
            w_dup[24:20] = remap(w_head[24:20]);
         end
         OP_I: begin
            w_dup[11:7]  = remap(w_head[11:7]);
            w_dup[19:15] = remap(w_head[19:15]);
         end
         OP_LOAD: begin
            w_dup[11:7]  = remap(w_head[11:7]);
            w_dup[19:15] = remap(w_head[19:15]);
            w_dup[30]    = 1'b1;
         end
         // Store bits [11:7] are immediate, not rd.
         OP_STORE: begin
            w_dup[19:15] = remap(w_head[19:15]);
            w_dup[24:20] = remap(w_head[24:20]);
            w_dup[30]    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr[AW-1:0]] <= ifu_qed_instruction;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_ORIG;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_out      <= NOP;
         r_vld      <= 1'b0;
         r_check    <= 1'b0;
         r_num_orig <= '0;
         r_num_dup  <= '0;
         r_drain    <= '0;
      end else if (w_adv) begin
         case (r_state)
            S_ORIG: begin
               r_out <= ifu_qed_instruction;
               r_vld <= ~w_filtered;
               if (w_push) begin
                  r_wr_ptr <= r_wr_ptr + L_ONE;
                  if (r_num_orig != CNT_MAX)
                     r_num_orig <= r_num_orig + 1'b1;
               end
               if ((exec_dup && !w_empty) || w_fill)
                  r_state <= S_DUP;
            end
            S_DUP: begin
               r_out    <= w_dup;
               r_vld    <= 1'b1;
               r_rd_ptr <= r_rd_ptr + L_ONE;
               if (r_num_dup != CNT_MAX)
                  r_num_dup <= r_num_dup + 1'b1;
               if (w_level == L_ONE) begin
                  r_state <= S_DRAIN;
                  r_drain <= DW'(DRAIN_CYCLES);
               end
            end
            S_DRAIN: begin
               r_out <= NOP;
               r_vld <= 1'b0;
               if (r_drain == '0) begin
                  r_state <= S_CHECK;
                  r_check <= 1'b1;
               end else begin
                  r_drain <= r_drain - 1'b1;
               end
            end
            default: begin
               r_out <= NOP;
               r_vld <= 1'b0;
            end
         endcase
      end
   end

   assign qed_ifu_instruction = ena ? r_out : ifu_qed_instruction;
   assign vld_out             = ena ? r_vld : 1'b1;
   assign qed_check_valid     = ena & r_check;
   assign num_orig            = r_num_orig;
   assign num_dup             = r_num_dup;
   assign buf_full            = w_full;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Randomized bench for qed_dup_scheduler against a queue-based model of the ORIG/DUP/drain/check sequence.
// Build with QED_NOP_FILTER_EN defined to exercise the NOP filter.
module tb_qed_dup_scheduler;
   localparam int DEPTH        = 8;
   localparam int DRAIN_CYCLES = 5;
   localparam int CNT_W        = 6;
   localparam logic [31:0] NOP = 32'h0000007F;
   localparam int M_ORIG = 0, M_DUP = 1, M_DRAIN = 2, M_CHECK = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic             exec_dup;
   logic [31:0]      ifu_qed_instruction;
   logic             stall_IF;
   logic [31:0]      qed_ifu_instruction;
   logic             vld_out;
   logic             qed_check_valid;
   logic [CNT_W-1:0] num_orig;
   logic [CNT_W-1:0] num_dup;
   logic             buf_full;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model
   logic [31:0] m_q[$];
   int          m_mode;
   logic [31:0] m_out;
   bit          m_vld, m_chk;
   int          m_norig, m_ndup, m_drain;

   qed_dup_scheduler #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ena                 (ena),
      .exec_dup            (exec_dup),
      .ifu_qed_instruction (ifu_qed_instruction),
      .stall_IF            (stall_IF),
      .qed_ifu_instruction (qed_ifu_instruction),
      .vld_out             (vld_out),
      .qed_check_valid     (qed_check_valid),
      .num_orig            (num_orig),
      .num_dup             (num_dup),
      .buf_full            (buf_full)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
   endtask

   // Duplicate derived from which register fields each instruction class actually uses.
   function automatic logic [31:0] ref_dup(input logic [31:0] ins);
      logic [31:0] r;
      bit use_rd, use_rs1, use_rs2, is_mem;
      r = ins;
      use_rd = 0; use_rs1 = 0; use_rs2 = 0; is_mem = 0;
      case (ins[6:0])
         7'h33: begin use_rd = 1; use_rs1 = 1; use_rs2 = 1; end
         7'h13: begin use_rd = 1; use_rs1 = 1; end
         7'h03: begin use_rd = 1; use_rs1 = 1; is_mem = 1; end
         7'h23: begin use_rs1 = 1; use_rs2 = 1; is_mem = 1; end
         default: ;
      endcase
      if (use_rd  && r[11:7]  != 0) r[11:7]  = r[11:7]  + 5'd16;
      if (use_rs1 && r[19:15] != 0) r[19:15] = r[19:15] + 5'd16;
      if (use_rs2 && r[24:20] != 0) r[24:20] = r[24:20] + 5'd16;
      if (is_mem) r[30] = 1'b1;
      return r;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= (1 << CNT_W) - 1) ? v : v + 1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_mode = M_ORIG; m_out = NOP; m_vld = 0; m_chk = 0;
      m_norig = 0; m_ndup = 0; m_drain = 0;
   endtask

   task automatic model_step();
      bit drop, had_entries;
      if (!(ena && !stall_IF)) return;
      case (m_mode)
         M_ORIG: begin
`ifdef QED_NOP_FILTER_EN
            drop = (ifu_qed_instruction[6:0] == 7'h7F);
`else
            drop = 0;
`endif
            had_entries = (m_q.size() > 0);
            m_out = ifu_qed_instruction;
            m_vld = !drop;
            if (!drop) begin
               m_q.push_back(ifu_qed_instruction);
               m_norig = sat_inc(m_norig);
            end
            if ((exec_dup && had_entries) || m_q.size() == DEPTH) m_mode = M_DUP;
         end
         M_DUP: begin
            m_out = ref_dup(m_q.pop_front());
            m_vld = 1;
            m_ndup = sat_inc(m_ndup);
            if (m_q.size() == 0) begin m_mode = M_DRAIN; m_drain = DRAIN_CYCLES; end
         end
         M_DRAIN: begin
            m_out = NOP; m_vld = 0;
            if (m_drain == 0) begin m_mode = M_CHECK; m_chk = 1; end
            else m_drain--;
         end
         default: begin m_out = NOP; m_vld = 0; end
      endcase
   endtask

   task automatic compare_all(input string pfx);
      check_val({pfx, "_instr"}, qed_ifu_instruction, ena ? m_out : ifu_qed_instruction);
      check_val({pfx, "_vld"},   32'(vld_out),         ena ? 32'(m_vld) : 32'd1);
      check_val({pfx, "_chk"},   32'(qed_check_valid), ena ? 32'(m_chk) : 32'd0);
      check_val({pfx, "_norig"}, 32'(num_orig),        32'(m_norig));
      check_val({pfx, "_ndup"},  32'(num_dup),         32'(m_ndup));
      check_val({pfx, "_full"},  32'(buf_full),        32'(m_q.size() == DEPTH));
   endtask

   // Inputs are driven here, just after the previous rising edge.
   task automatic cycle(input string pfx, input bit e, input bit st, input bit ex, input logic [31:0] ins);
      ena = e; stall_IF = st; exec_dup = ex; ifu_qed_instruction = ins;
      @(posedge clk);
      model_step();
      #1;
      $display("%s ena=%0b stall=%0b exec=%0b in=%08h out=%08h vld=%0b chk=%0b orig=%0d dup=%0d",
               pfx, e, st, ex, ins, qed_ifu_instruction, vld_out, qed_check_valid, num_orig, num_dup);
      compare_all(pfx);
   endtask

   task automatic do_reset();
      ena = 1; stall_IF = 0; exec_dup = 0; ifu_qed_instruction = NOP;
      rst = 1;
      model_reset();
      #2;
      compare_all("rst");
      #1 rst = 0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      int k;
      ins = $urandom;
      k = $urandom_range(0, 5);
      case (k)
         0: begin ins[6:0] = 7'h33; ins[11] = 0; ins[19] = 0; ins[24] = 0; ins[31:25] = ins[30] ? 7'h20 : 7'h00; end
         1, 5: begin ins[6:0] = 7'h13; ins[11] = 0; ins[19] = 0; end
         2: begin ins[6:0] = 7'h03; ins[11] = 0; ins[19] = 0; end
         3: begin ins[6:0] = 7'h23; ins[19] = 0; ins[24] = 0; end
         default: ins = NOP;
      endcase
      return ins;
   endfunction

   initial begin
      rst = 1; ena = 1; stall_IF = 0; exec_dup = 0; ifu_qed_instruction = NOP;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // Basic replay: ADDI x1,x2,5 then LW x3,0(x0) with exec_dup
      do_reset();
      cycle("basic", 1, 0, 0, 32'h00510093);
      cycle("basic", 1, 0, 1, 32'h00002183);
      cycle("basic", 1, 0, 0, NOP);
      check_val("dup_addi", qed_ifu_instruction, 32'h00590893);
      cycle("basic", 1, 0, 0, NOP);
      check_val("dup_lw", qed_ifu_instruction, 32'h40002983);
      for (int i = 0; i < DRAIN_CYCLES; i++) begin
         cycle("drain", 1, 0, 0, NOP);
         check_val("drain_no_chk", 32'(qed_check_valid), 32'd0);
      end
      cycle("drain", 1, 0, 0, NOP);
      check_val("chk_set", 32'(qed_check_valid), 32'd1);
      check_val("chk_counts", 32'(num_dup), 32'd2);

      // exec_dup with empty FIFO at reset release stays in ORIG
      do_reset();
      cycle("empty_exec", 1, 0, 1, 32'h00510093);
      check_val("empty_exec_norig", 32'(num_orig), 32'd1);
      cycle("empty_exec", 1, 0, 0, 32'h003100B3);
      check_val("empty_exec_stay", qed_ifu_instruction, 32'h003100B3);

      // Forced switch on full FIFO, stall mid-DUP, async reset in DRAIN
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         cycle("force", 1, 0, 0, {7'h00, 5'(i % 16), 5'((i + 3) % 16), 3'b000, 5'((i + 1) % 16), 7'h33});
      check_val("force_full", 32'(buf_full), 32'd1);
      for (int i = 0; i < 3; i++) cycle("dup", 1, 0, 0, rand_instr());
      for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, rand_instr());
      for (int i = 3; i < DEPTH; i++) cycle("dup", 1, 0, 0, rand_instr());
      check_val("force_ndup", 32'(num_dup), 32'(DEPTH));
      cycle("drain", 1, 0, 0, NOP);
      cycle("drain", 1, 0, 0, NOP);
      #2 rst = 1;
      #1;
      check_val("async_instr", qed_ifu_instruction, NOP);
      check_val("async_chk",   32'(qed_check_valid), 32'd0);
      check_val("async_norig", 32'(num_orig), 32'd0);
      check_val("async_ndup",  32'(num_dup), 32'd0);
      model_reset();
      #1 rst = 0;
      cycle("post_rst", 1, 0, 0, NOP);

      // Randomized episodes
      for (int ep = 0; ep < 8; ep++) begin
         int after;
         after = 0;
         do_reset();
         for (int c = 0; c < 400 && after < 3; c++) begin
            cycle("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), rand_instr());
            if (m_mode == M_CHECK) after++;
         end
         cycle("final", 1, 0, 0, rand_instr());
         check_val("final_chk", 32'(qed_check_valid), 32'd1);
         check_val("final_eq", 32'(num_orig), 32'(num_dup));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
